// File: rtl/risc_pkg.sv
// Shared definitions for the RISC controller: FSM states, opcodes, ALU select
// codes and instruction field positions.
package risc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;

  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BNZ  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd1;
  localparam logic [2:0] SEL_AND = 3'd2;
  localparam logic [2:0] SEL_OR  = 3'd3;
  localparam logic [2:0] SEL_XOR = 3'd4;
  localparam logic [2:0] SEL_NOT = 3'd5;
  localparam logic [2:0] SEL_SHL = 3'd6;
  localparam logic [2:0] SEL_SHR = 3'd7;

  localparam int IR_ALU_BIT = 15;
  localparam int IR_OP_HI   = 15;
  localparam int IR_OP_LO   = 12;
  localparam int IR_SEL_HI  = 14;
  localparam int IR_SEL_LO  = 12;
  localparam int IR_RD_HI   = 11;
  localparam int IR_RD_LO   = 10;
  localparam int IR_RA_HI   = 9;
  localparam int IR_RA_LO   = 8;
  localparam int IR_RB_HI   = 7;
  localparam int IR_RB_LO   = 6;
  localparam int IR_IMM_HI  = 7;
  localparam int IR_IMM_LO  = 0;

  function automatic logic is_alu_op(input logic [15:0] ir);
    return ~ir[IR_ALU_BIT];
  endfunction

endpackage

// File: rtl/risc_regfile.sv
// 4x8 register file: two async read ports, one debug read port and one
// synchronous write port, synchronously reset to zero.
module risc_regfile
  import risc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [REG_AW-1:0] i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the array is built from flops, so clearing it in a reset loop is
      // legal here; a RAM-macro-backed array could not be reset this way.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_regs[i_raddr_a];
  assign o_rdata_b  = r_regs[i_raddr_b];
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving an external 8-bit ALU.
// Define RISC_BNZ_EN to turn opcode 4'hB into BNZ (otherwise it is a NOP).
module alu_control_unit
  import risc_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  output logic        ImemReq,
  output logic [7:0]  Pc,
  input  logic        ImemAck,
  input  logic [15:0] Instr,
  output logic [2:0]  Sel,
  output logic [7:0]  InA,
  output logic [7:0]  InB,
  input  logic [7:0]  Oper,
  input  logic        Zero,
  output logic        Busy,
  output logic        Halted,
  input  logic [1:0]  DbgSel,
  output logic [7:0]  DbgData
);

  state_t r_state, w_next_state;

  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [2:0]  r_sel;
  logic [7:0]  r_ina, r_inb;
  logic        r_z;

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_rd, w_ra, w_rb;
  logic [7:0]        w_imm, w_pc_inc, w_pc_next;
  logic [7:0]        w_rdata_a, w_rdata_b, w_reg_wdata;
  logic              w_taken, w_ir_load, w_opnd_load, w_pc_load, w_z_we, w_reg_we;

  assign w_op     = r_ir[IR_OP_HI:IR_OP_LO];
  assign w_rd     = r_ir[IR_RD_HI:IR_RD_LO];
  assign w_ra     = r_ir[IR_RA_HI:IR_RA_LO];
  assign w_rb     = r_ir[IR_RB_HI:IR_RB_LO];
  assign w_imm    = r_ir[IR_IMM_HI:IR_IMM_LO];
  assign w_pc_inc = r_pc + 8'd1;

  risc_regfile u_regfile (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_we       (w_reg_we),
    .i_waddr    (w_rd),
    .i_wdata    (w_reg_wdata),
    .i_raddr_a  (w_ra),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (w_rb),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_sel  (DbgSel),
    .o_dbg_data (DbgData)
  );

  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_BZ:  w_taken = r_z;
      OP_JMP: w_taken = 1'b1;
`ifdef RISC_BNZ_EN
      OP_BNZ: w_taken = ~r_z;
`endif
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case statement can leave a latch behind.
    w_next_state = r_state;
    w_ir_load    = 1'b0;
    w_opnd_load  = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_next    = w_pc_inc;
    w_z_we       = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_wdata  = Oper;
    case (r_state)
      ST_IDLE: if (Start) w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (ImemAck) begin
          w_ir_load    = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu_op(r_ir)) begin
          w_opnd_load  = 1'b1;
          w_next_state = ST_EXEC;
        end else if (w_op == OP_HALT) begin
          w_next_state = ST_HALT;
        end else begin
          w_pc_load    = 1'b1;
          w_pc_next    = w_taken ? w_imm : w_pc_inc;
          w_reg_we     = (w_op == OP_LDI);
          w_reg_wdata  = w_imm;
          w_next_state = ST_FETCH;
        end
      end
      ST_EXEC: begin
        w_reg_we     = 1'b1;
        w_z_we       = 1'b1;
        w_pc_load    = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
      r_sel <= '0;
      r_ina <= '0;
      r_inb <= '0;
      r_z   <= 1'b0;
    end else begin
      if (w_ir_load) r_ir <= Instr;
      if (w_opnd_load) begin
        r_sel <= r_ir[IR_SEL_HI:IR_SEL_LO];
        r_ina <= w_rdata_a;
        r_inb <= w_rdata_b;
      end
      if (w_pc_load) r_pc <= w_pc_next;
      if (w_z_we)    r_z  <= Zero;
    end
  end

  assign ImemReq = (r_state == ST_FETCH);
  assign Busy    = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);
  assign Halted  = (r_state == ST_HALT);
  assign Pc      = r_pc;
  assign Sel     = r_sel;
  assign InA     = r_ina;
  assign InB     = r_inb;

endmodule

// File: tb/tb_alu_control_unit.sv
// Scoreboard bench for alu_control_unit: a program in a modelled instruction
// memory, an ALU model, and a monitor that checks each new fetch.
module tb_alu_control_unit;

  logic        Clk = 1'b0;
  logic        Rst, Start, ImemReq, ImemAck, Zero, Busy, Halted;
  logic [7:0]  Pc, InA, InB, Oper, DbgData;
  logic [15:0] Instr;
  logic [2:0]  Sel;
  logic [1:0]  DbgSel;

  always #5 Clk = ~Clk;

  alu_control_unit #(.RESET_PC(8'h10)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ImemReq(ImemReq), .Pc(Pc),
    .ImemAck(ImemAck), .Instr(Instr), .Sel(Sel), .InA(InA), .InB(InB),
    .Oper(Oper), .Zero(Zero), .Busy(Busy), .Halted(Halted),
    .DbgSel(DbgSel), .DbgData(DbgData)
  );

  always_comb begin
    Oper = 8'h00;
    case (Sel)
      3'd0: Oper = InA + InB;
      3'd1: Oper = InA - InB;
      3'd2: Oper = InA & InB;
      3'd3: Oper = InA | InB;
      3'd4: Oper = InA ^ InB;
      3'd5: Oper = ~InA;
      3'd6: Oper = InA << 1;
      3'd7: Oper = InA >> 1;
      default: Oper = 8'h00;
    endcase
    Zero = (Oper == 8'h00);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected state at the start of each fetch: Pc, cycles since previous
  // fetch start (0 = don't care) and one register value.
  typedef struct {
    logic [7:0] pc;
    int         gap;
    logic [1:0] sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input logic [7:0] pc, input int gap, input logic [1:0] sel,
                          input logic [7:0] val);
    exp_t e;
    e.pc = pc; e.gap = gap; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  logic [15:0] imem [256];
  int          imem_delay [256];
  logic        hold_ack = 1'b0;

  // Instruction memory: acks after imem_delay cycles; outside a request it
  // drives a spurious ack carrying HALT, which must be ignored.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ImemAck  = 1'b1;
    Instr    = 16'hFFFF;
    forever begin
      @(negedge Clk);
      Instr = 16'hFFFF;
      if (ImemReq && !hold_ack) begin
        if (wait_cnt == imem_delay[Pc]) begin
          ImemAck  = 1'b1;
          Instr    = imem[Pc];
          wait_cnt = 0;
        end else begin
          ImemAck  = 1'b0;
          wait_cnt++;
        end
      end else begin
        ImemAck  = !ImemReq;
        wait_cnt = 0;
      end
    end
  end

  int         mon_cyc = 0;
  int         last_start = 0;
  logic       prev_req = 1'b0;
  logic [7:0] fetch_pc = 8'h00;

  initial begin
    exp_t e;
    DbgSel = 2'd0;
    forever begin
      @(negedge Clk);
      mon_cyc++;
      if (ImemReq && !prev_req) begin
        fetch_pc = Pc;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_fetch: fetch at Pc=0x%0h, expected no fetch", Pc);
        end else begin
          e = sb.pop_front();
          DbgSel = e.sel;
          #1;
          check("fetch_pc", Pc, e.pc);
          check($sformatf("reg_R%0d", e.sel), DbgData, e.val);
          if (e.gap != 0) check("fetch_gap", mon_cyc - last_start, e.gap);
        end
        last_start = mon_cyc;
      end else if (ImemReq) begin
        check("pc_hold", Pc, fetch_pc);
      end
      prev_req = ImemReq;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [7:0] addr, input logic [15:0] ins, input int dly);
    imem[addr]       = ins;
    imem_delay[addr] = dly;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i]       = 16'hF000;
      imem_delay[i] = 0;
    end
    load(8'h10, 16'h8405, 0);  // LDI R1,05
    load(8'h11, 16'h8803, 0);  // LDI R2,03
    load(8'h12, 16'h0180, 0);  // ADD R0,R1,R2
    load(8'h13, 16'h1D40, 0);  // SUB R3,R1,R1
    load(8'h14, 16'h9020, 0);  // BZ 20 (taken)
    load(8'h20, 16'h0180, 0);  // ADD R0,R1,R2
    load(8'h21, 16'h9040, 0);  // BZ 40 (not taken)
    load(8'h22, 16'h80AA, 3);  // LDI R0,AA with 3-cycle ack delay
    load(8'h23, 16'h4580, 0);  // XOR R1,R1,R2
    load(8'h24, 16'hA0FF, 0);  // JMP FF
    load(8'hFF, 16'h8C5A, 0);  // LDI R3,5A, Pc wraps
    load(8'h00, 16'hB030, 0);  // BNZ 30 or NOP
    load(8'h01, 16'hD123, 0);  // NOP
    load(8'h02, 16'hF000, 0);  // HALT
    load(8'h30, 16'hF000, 0);  // HALT

    push_exp(8'h10, 0, 2'd0, 8'h00);
    push_exp(8'h11, 2, 2'd1, 8'h05);
    push_exp(8'h12, 2, 2'd2, 8'h03);
    push_exp(8'h13, 3, 2'd0, 8'h08);
    push_exp(8'h14, 3, 2'd3, 8'h00);
    push_exp(8'h20, 2, 2'd1, 8'h05);
    push_exp(8'h21, 3, 2'd0, 8'h08);
    push_exp(8'h22, 2, 2'd2, 8'h03);
    push_exp(8'h23, 5, 2'd0, 8'hAA);
    push_exp(8'h24, 3, 2'd1, 8'h06);
    push_exp(8'hFF, 2, 2'd1, 8'h06);
    push_exp(8'h00, 2, 2'd3, 8'h5A);
`ifdef RISC_BNZ_EN
    push_exp(8'h30, 2, 2'd0, 8'hAA);
`else
    push_exp(8'h01, 2, 2'd3, 8'h5A);
    push_exp(8'h02, 2, 2'd2, 8'h03);
`endif

    Rst   = 1'b1;
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_pc", Pc, 8'h10);
    check("rst_req", ImemReq, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_halted", Halted, 1'b0);
    check("rst_sel", Sel, 3'd0);
    check("rst_ina", InA, 8'h00);
    check("rst_inb", InB, 8'h00);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("idle_ignores_ack", Busy, 1'b0);

    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("req_after_start", ImemReq, 1'b1);
    check("busy_in_fetch", Busy, 1'b1);

    for (int i = 0; i < 300 && !Halted; i++) @(negedge Clk);
    check("halt_reached", Halted, 1'b1);
    check("halt_busy", Busy, 1'b0);
    check("halt_req", ImemReq, 1'b0);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("halt_sticky", Halted, 1'b1);
    check("halt_no_fetch", ImemReq, 1'b0);
    check("sb_drained", sb.size(), 0);

    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("rst2_halted", Halted, 1'b0);
    check("rst2_sel", Sel, 3'd0);
    check("rst2_ina", InA, 8'h00);
    check("rst2_inb", InB, 8'h00);
    check("rst2_pc", Pc, 8'h10);
    check("rst2_regs", DbgData, 8'h00);

    push_exp(8'h10, 0, 2'd1, 8'h00);
    hold_ack = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("midfetch_req", ImemReq, 1'b1);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("midfetch_rst_req", ImemReq, 1'b0);
    check("midfetch_rst_busy", Busy, 1'b0);
    check("midfetch_rst_pc", Pc, 8'h10);
    hold_ack = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("late_ack_busy", Busy, 1'b0);
    check("late_ack_req", ImemReq, 1'b0);
    check("late_ack_halted", Halted, 1'b0);
    check("sb_drained_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
